// File: rtl/uart_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_pkg
// Description : Shared types and constants for the framed UART program loader:
//               parser state encoding, ack/nak codes, default sync marker,
//               frame length and the frame checksum helper.
//               Optional feature macro (used by uart_prog_loader):
//               UART_PROG_LOADER_ACK_EN
// Revision    : 1.0 - initial release
// ============================================================================
package uart_prog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_SYNC = 2'd1,
        ST_GOT_ADDR = 2'd2,
        ST_GOT_DATA = 2'd3
    } state_t;

    localparam logic [7:0] ACK_BYTE          = 8'h06;
    localparam logic [7:0] NAK_BYTE          = 8'h15;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         FRAME_LEN         = 4;

    // Expected checksum byte for a frame: XOR of sync, address and data.
    function automatic logic [7:0] frame_chk(input logic [7:0] sync,
                                             input logic [3:0] addr,
                                             input logic [7:0] data);
        return sync ^ {4'h0, addr} ^ data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader_if
// Description : Bundle of the loader's byte-stream input, RAM write port,
//               ack/nak transmit request and status outputs.
//               master = loader side, slave = surrounding system side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_prog_loader_if;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_active;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       busy;
    logic [7:0] err_count;
    logic [3:0] led;

    modport master (
        input  rx_dv, rx_byte, tx_active,
        output ram_addr, ram_data, ram_we, tx_dv, tx_byte, busy, err_count, led
    );

    modport slave (
        output rx_dv, rx_byte, tx_active,
        input  ram_addr, ram_data, ram_we, tx_dv, tx_byte, busy, err_count, led
    );
endinterface
`default_nettype wire

// File: rtl/uart_prog_loader_inter_byte_timer.sv
`default_nettype none
// ============================================================================
// Module      : inter_byte_timer
// Description : Counts clocks while enabled; cleared on every received byte
//               and whenever disabled. Raises expire once the count reaches
//               TIMEOUT_CLKS while still enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module inter_byte_timer #(
    parameter int TIMEOUT_CLKS = 5_000_000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expire
);
    localparam int              CW    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CLKS);

    logic [CW-1:0] count;

    // Idle-time counter; holds at the limit so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_prog_loader
// Description : Parses SYNC/ADDR/DATA/CHK frames from the UART receiver and
//               issues one-cycle writes into a 16-entry RAM. Bad address,
//               bad checksum and inter-byte timeout reject the frame and bump
//               a saturating error counter.
//               Optional: define UART_PROG_LOADER_ACK_EN to send an ack/nak
//               byte per frame result through the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_prog_loader
    import uart_prog_pkg::*;
#(
    parameter int         TIMEOUT_CLKS = 5_000_000,
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  wire logic          clk,
    input  wire logic          rst,
    uart_prog_loader_if.master bus
);
    state_t     state, state_next;
    logic [3:0] addr_q;
    logic [7:0] data_q;
    logic       do_write, do_error, latch_addr, latch_data;
    logic       expire;

    logic [3:0] ram_addr_q, led_q;
    logic [7:0] ram_data_q, err_count_q;
    logic       ram_we_q;

    inter_byte_timer #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.rx_dv),
        .enable (state != ST_IDLE),
        .expire (expire)
    );

    // Parser state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next state and per-cycle frame actions; a received byte takes
    // priority over a timeout in the same cycle.
    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        do_error   = 1'b0;
        latch_addr = 1'b0;
        latch_data = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.rx_dv && bus.rx_byte == SYNC_BYTE) state_next = ST_GOT_SYNC;
            end
            ST_GOT_SYNC: begin
                if (bus.rx_dv) begin
                    if (bus.rx_byte[7:4] != 4'h0) begin
                        do_error   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        latch_addr = 1'b1;
                        state_next = ST_GOT_ADDR;
                    end
                end else if (expire) begin
                    do_error   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_GOT_ADDR: begin
                if (bus.rx_dv) begin
                    latch_data = 1'b1;
                    state_next = ST_GOT_DATA;
                end else if (expire) begin
                    do_error   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_GOT_DATA: begin
                if (bus.rx_dv) begin
                    if (bus.rx_byte == frame_chk(SYNC_BYTE, addr_q, data_q)) do_write = 1'b1;
                    else                                                     do_error = 1'b1;
                    state_next = ST_IDLE;
                end else if (expire) begin
                    do_error   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Captured address and data bytes of the frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (latch_addr) addr_q <= bus.rx_byte[3:0];
            if (latch_data) data_q <= bus.rx_byte;
        end
    end

    // RAM write port, status LEDs and saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_we_q    <= 1'b0;
            led_q       <= '0;
            err_count_q <= '0;
        end else begin
            ram_we_q <= do_write;
            if (do_write) begin
                ram_addr_q <= addr_q;
                ram_data_q <= data_q;
                led_q      <= addr_q;
            end
            if (do_error && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_data  = ram_data_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.led       = led_q;
    assign bus.err_count = err_count_q;
    assign bus.busy      = (state != ST_IDLE);

`ifdef UART_PROG_LOADER_ACK_EN
    logic       pending, tx_dv_q, cand_valid;
    logic [7:0] pending_byte, tx_byte_q, cand_byte;

    // A fresh result replaces any unsent one in the single pending slot.
    always_comb begin
        cand_valid = do_write || do_error || pending;
        cand_byte  = pending_byte;
        if (do_write)      cand_byte = ACK_BYTE;
        else if (do_error) cand_byte = NAK_BYTE;
    end

    // Send immediately when the transmitter is free, otherwise hold pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending      <= 1'b0;
            pending_byte <= '0;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= '0;
        end else begin
            tx_dv_q      <= cand_valid && !bus.tx_active;
            pending      <= cand_valid && bus.tx_active;
            pending_byte <= cand_byte;
            if (cand_valid && !bus.tx_active) tx_byte_q <= cand_byte;
        end
    end

    assign bus.tx_dv   = tx_dv_q;
    assign bus.tx_byte = tx_byte_q;
`else
    logic unused_tx_active;
    assign unused_tx_active = bus.tx_active;
    assign bus.tx_dv        = 1'b0;
    assign bus.tx_byte      = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_prog_loader
// Description : Directed plus randomized frames against a queue-based
//               reference model of the framing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_prog_loader;
    import uart_prog_pkg::*;

    localparam int TB_TIMEOUT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_prog_loader_if bus();

    uart_prog_loader #(.TIMEOUT_CLKS(TB_TIMEOUT), .SYNC_BYTE(8'hA5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // DUT observation (sampled on the falling edge)
    int         wr_cnt = 0;
    int         tx_cnt = 0;
    logic [7:0] tx_last = 8'h00;
    logic [7:0] dut_mem [16];

    // Reference model
    logic [7:0] frame [$];
    int         exp_err = 0;
    logic [3:0] exp_led = 4'h0;
    logic [3:0] exp_ram_addr = 4'h0;
    logic [7:0] exp_ram_data = 8'h00;
    int         exp_wr = 0;
    logic [7:0] exp_mem [16];
    int         exp_tx_cnt = 0;
    logic [7:0] exp_tx_last = 8'h00;
    bit         m_tx_busy = 1'b0;
    bit         m_pend = 1'b0;
    logic [7:0] m_pend_byte = 8'h00;

    always @(negedge clk) begin
        if (bus.ram_we) begin
            wr_cnt++;
            dut_mem[bus.ram_addr] = bus.ram_data;
        end
        if (bus.tx_dv) begin
            tx_cnt++;
            tx_last = bus.tx_byte;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_tx(input logic [7:0] b);
        if (m_tx_busy) begin
            m_pend      = 1'b1;
            m_pend_byte = b;
        end else begin
            exp_tx_cnt++;
            exp_tx_last = b;
        end
    endtask

    task automatic model_reject();
        frame.delete();
        if (exp_err < 255) exp_err++;
        model_tx(NAK_BYTE);
    endtask

    task automatic model_feed(input logic [7:0] b);
        logic [7:0] x;
        if (frame.size() == 0) begin
            if (b == 8'hA5) frame.push_back(b);
        end else begin
            frame.push_back(b);
            if (frame.size() == 2 && b[7:4] != 4'h0) begin
                model_reject();
            end else if (frame.size() == FRAME_LEN) begin
                x = 8'h00;
                foreach (frame[i]) x ^= frame[i];
                if (x == 8'h00) begin
                    exp_wr++;
                    exp_ram_addr = frame[1][3:0];
                    exp_ram_data = frame[2];
                    exp_led      = frame[1][3:0];
                    exp_mem[frame[1][3:0]] = frame[2];
                    model_tx(ACK_BYTE);
                    frame.delete();
                end else begin
                    model_reject();
                end
            end
        end
    endtask

    task automatic model_timeout();
        if (frame.size() != 0) model_reject();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_dv   = 1'b1;
        bus.rx_byte = b;
        @(negedge clk);
        bus.rx_dv   = 1'b0;
        model_feed(b);
        repeat (9) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(d);
        send_byte(c);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".err"},  32'(bus.err_count), 32'(exp_err));
        check({tag, ".led"},  32'(bus.led),       32'(exp_led));
        check({tag, ".wr"},   32'(wr_cnt),        32'(exp_wr));
        check({tag, ".busy"}, 32'(bus.busy),      32'(frame.size() != 0));
        check({tag, ".addr_data"}, {20'h0, bus.ram_addr, bus.ram_data},
                                   {20'h0, exp_ram_addr, exp_ram_data});
`ifdef UART_PROG_LOADER_ACK_EN
        check({tag, ".tx"}, {tx_cnt[23:0], tx_last}, {exp_tx_cnt[23:0], exp_tx_last});
`else
        check({tag, ".tx"}, {tx_cnt[23:0], bus.tx_byte}, 32'h0);
`endif
    endtask

    initial begin
        logic [7:0] a, d, c, g;
        int kind, n;

        for (int i = 0; i < 16; i++) begin
            dut_mem[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end
        bus.rx_dv     = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.tx_active = 1'b0;

        // Reset values
        #2;
        check("reset.outputs", {bus.ram_addr, bus.ram_data, bus.ram_we, bus.tx_dv, bus.tx_byte, bus.busy, 2'b00},
                               32'h0);
        check("reset.err_led", {bus.err_count, bus.led}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Valid frame A5 03 5C FA with write latency check
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h5C);
        @(negedge clk);
        bus.rx_dv   = 1'b1;
        bus.rx_byte = 8'hFA;
        @(negedge clk);
        bus.rx_dv   = 1'b0;
        model_feed(8'hFA);
        check("frame_a.we_latency", {bus.ram_we, bus.ram_addr, bus.ram_data}, {19'h0, 1'b1, 4'h3, 8'h5C});
        @(negedge clk);
        check("frame_a.we_one_cycle", 32'(bus.ram_we), 32'h0);
        repeat (8) @(negedge clk);
        check_all("frame_a");

        // Bad checksum
        send_frame(8'h03, 8'h5C, 8'h00);
        check_all("bad_chk");

        // Bad address on second byte
        send_byte(8'hA5);
        send_byte(8'h13);
        check_all("bad_addr");

        // Timeout after A5 01
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (25) @(negedge clk);
        check("timeout.busy_before", 32'(bus.busy), 32'h1);
        repeat (10) @(negedge clk);
        model_timeout();
        check_all("timeout");
        send_frame(8'h07, 8'h42, 8'hA5 ^ 8'h07 ^ 8'h42);
        check_all("after_timeout");

        // Garbage then valid frame to address 15
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h12);
        check_all("garbage");
        send_frame(8'h0F, 8'h99, 8'hA5 ^ 8'h0F ^ 8'h99);
        check_all("addr15");

`ifdef UART_PROG_LOADER_ACK_EN
        // Transmitter busy: nak then ack; only the ack is sent on release
        bus.tx_active = 1'b1;
        m_tx_busy     = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h20);
        send_frame(8'h02, 8'h11, 8'hA5 ^ 8'h02 ^ 8'h11);
        check_all("tx_held");
        bus.tx_active = 1'b0;
        m_tx_busy     = 1'b0;
        if (m_pend) begin
            exp_tx_cnt++;
            exp_tx_last = m_pend_byte;
            m_pend = 1'b0;
        end
        repeat (3) @(negedge clk);
        check_all("tx_release");
`endif

        // Randomized frames
        for (int it = 0; it < 60; it++) begin
            kind = $urandom_range(0, 5);
            a = 8'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            c = 8'hA5 ^ a ^ d;
            case (kind)
                0, 1: send_frame(a, d, c);
                2: send_frame(a, d, c ^ 8'($urandom_range(1, 255)));
                3: begin
                    send_byte(8'hA5);
                    send_byte({4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))});
                end
                4: begin
                    g = 8'($urandom_range(0, 255));
                    if (g == 8'hA5) g = 8'h00;
                    send_byte(g);
                end
                default: begin
                    n = $urandom_range(0, 2);
                    send_byte(8'hA5);
                    if (n > 0) send_byte(a);
                    if (n > 1) send_byte(d);
                    repeat (TB_TIMEOUT) @(negedge clk);
                    model_timeout();
                end
            endcase
            if (it % 6 == 5) check_all("random");
        end
        check_all("random_end");

        // Saturation with 300 bad frames
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) begin
                send_byte(8'hA5);
                send_byte(8'hF0);
            end else begin
                send_frame(8'h01, 8'h01, 8'h00);
            end
        end
        check_all("saturate");
        check("saturate.ff", 32'(bus.err_count), 32'hFF);

        // Reset mid-frame: outputs return to reset values immediately
        send_byte(8'hA5);
        send_byte(8'h04);
        #3;
        rst = 1'b1;
        #1;
        check("midrst.outputs", {bus.ram_addr, bus.ram_data, bus.ram_we, bus.tx_dv, bus.tx_byte, bus.busy, 2'b00},
                                32'h0);
        check("midrst.err_led", {bus.err_count, bus.led}, 32'h0);
        frame.delete();
        exp_err      = 0;
        exp_led      = 4'h0;
        exp_ram_addr = 4'h0;
        exp_ram_data = 8'h00;
        exp_tx_last  = tx_last;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h33);
        check_all("after_rst");
        send_frame(8'h0A, 8'h5A, 8'hA5 ^ 8'h0A ^ 8'h5A);
        check_all("after_rst_frame");

        for (int i = 0; i < 16; i++) check($sformatf("mem[%0d]", i), 32'(dut_mem[i]), 32'(exp_mem[i]));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_prog_loader.md
# uart_prog_loader

Framed program loader sitting directly downstream of the UART receiver in the serial programming path. Consumes the receiver's byte stream (`rx_dv`/`rx_byte`), parses 4-byte checksummed write frames, and issues single-cycle writes of 8-bit values into the 16-entry program/data RAM of the 8-bit computer. It replaces the raw "every byte is a write" behaviour with framing, checksum and inter-byte timeout, so line noise cannot corrupt memory.

## Interface
- `TIMEOUT_CLKS`, 5_000_000: max clocks between bytes inside a frame (100 ms at 50 MHz).
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `rx_dv`  in  1  one-cycle strobe, `rx_byte` valid.
- `rx_byte`  in  8  received byte.
- `tx_active`  in  1  transmitter busy (used only with ack enabled).
- `ram_addr`  out  4  write address.
- `ram_data`  out  8  write data.
- `ram_we`  out  1  one-cycle write strobe.
- `tx_dv`  out  1  one-cycle request to send `tx_byte`.
- `tx_byte`  out  8  ack/nak byte.
- `busy`  out  1  high while a frame is partially received.
- `err_count`  out  8  saturating count of rejected frames.
- `led`  out  4  last successfully written address.

## Operation
- Frame: SYNC, ADDR, DATA, CHK, where CHK = SYNC ^ ADDR ^ DATA.
- States: IDLE, GOT_SYNC, GOT_ADDR, GOT_DATA.
- IDLE: `rx_dv` with `rx_byte`==SYNC_BYTE -> GOT_SYNC; any other byte is discarded silently (no error).
- GOT_SYNC: on `rx_dv`, if `rx_byte[7:4]`!=0 -> error, IDLE; else latch addr -> GOT_ADDR.
- GOT_ADDR: on `rx_dv`, latch data -> GOT_DATA.
- GOT_DATA: on `rx_dv`, checksum match -> write, IDLE; mismatch -> error, IDLE.
- Write: `ram_addr`/`ram_data` updated and `ram_we`=1 for exactly one cycle; `led` <= addr.
- Error: `err_count` increments, saturates at 8'hFF.
- Timeout: counter cleared on every `rx_dv`, increments in non-IDLE states; reaching TIMEOUT_CLKS -> error, IDLE. Width: $clog2(TIMEOUT_CLKS+1).
- `busy` = (state != IDLE).
- `ram_addr`/`ram_data` hold their last values between writes.

## Timing
- Reset values: state IDLE, `ram_addr`=0, `ram_data`=0, `ram_we`=0, `tx_dv`=0, `tx_byte`=0, `busy`=0, `err_count`=0, `led`=0, timeout counter 0.
- `ram_we` asserted the cycle after the `rx_dv` carrying CHK (1-cycle latency); all outputs registered.
- Timeout and `rx_dv` in the same cycle: `rx_dv` wins, byte processed normally.
- Back-to-back frames: next SYNC accepted in the cycle after `ram_we`; no dead cycles required.
- Reset mid-frame: partial frame discarded, no write, no error count.
- `rx_dv` assumed ≤1 per 10 clocks; no internal buffering.

## Configuration
- `UART_PROG_LOADER_ACK_EN` defined: on write, ack 8'h06 queued; on error (incl. timeout), nak 8'h15 queued. Single pending slot; newer result overwrites an unsent one. `tx_dv` pulses one cycle when pending and `tx_active`==0, then pending clears. Earliest pulse: same cycle as `ram_we`.
- Undefined: `tx_dv`, `tx_byte` constant 0; `tx_active` ignored; no pending logic synthesized.

## Structure
- Shared package `uart_prog_pkg`: state enum, ACK (8'h06), NAK (8'h15), default SYNC_BYTE, frame length constant.
- One sub-module: `inter_byte_timer` (clear, enable, expire pulse).

## Test plan
- Frame A5 03 5C (A5^03^5C=FA) FA -> one `ram_we`, addr 3, data 8'h5C, `led`=3, `err_count`=0; with ACK_EN `tx_byte`=06.
- Frame A5 03 5C 00 -> no `ram_we`, `err_count`=1; with ACK_EN `tx_byte`=15.
- A5 then ADDR 8'h13 -> error on the address byte, IDLE, no write.
- A5 01, then silence TIMEOUT_CLKS clocks -> `busy` drops, `err_count`=1, following valid frame writes correctly.
- Garbage 00 FF 12 then a valid frame to addr 15 -> exactly one write, `err_count`=0.
- 300 bad frames -> `err_count` stuck at 8'hFF; assert `rst` mid-frame -> all outputs at reset values immediately.
